// File: rtl/balance_pid.sv
// Balance PID stage: clamps pitch to an error, keeps a saturating integrator and
// a two-sample derivative history, and emits a saturated 12-bit control word two clocks after each sample.
module balance_pid #(
  parameter logic signed [4:0] P_COEFF = 5'sd9,
  parameter logic signed [5:0] D_COEFF = 6'sd11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [15:0] ptch,
  input  logic               pwr_up,
  input  logic               rider_off,
  output logic signed [11:0] PID_cntrl,
  output logic               cntrl_vld
);

  logic signed [9:0]  err_d, err_q;
  logic signed [9:0]  prev1_q, prev2_q;
  logic signed [10:0] diff;
  logic signed [6:0]  dsat_d, dsat_q;
  logic signed [17:0] integ_q, integ_ext, integ_sum;
  logic               integ_ovf;
  logic               s1_vld_q;

  logic signed [14:0] p_term, i_term, d_term;
  logic signed [15:0] pid_sum;
  logic signed [11:0] pid_sat;

  // Stage 1: error clamp, integrator add with overflow detect, derivative diff
  always_comb begin
    if (ptch > 16'sd511)       err_d = 10'sd511;
    else if (ptch < -16'sd512) err_d = -10'sd512;
    else                       err_d = ptch[9:0];

    integ_ext = 18'(err_d);
    integ_sum = integ_q + integ_ext;
    integ_ovf = (integ_q[17] == integ_ext[17]) && (integ_sum[17] != integ_q[17]);

    diff = 11'(err_d) - 11'(prev2_q);
    if (diff > 11'sd63)        dsat_d = 7'sd63;
    else if (diff < -11'sd64)  dsat_d = -7'sd64;
    else                       dsat_d = diff[6:0];
  end

  // Stage 2: P + I + D from registered operands; integ already holds this sample
  always_comb begin
    p_term  = 15'(err_q) * 15'(P_COEFF);
    i_term  = 15'($signed(integ_q[17:6]));
    d_term  = 15'(dsat_q) * 15'(D_COEFF);
    pid_sum = 16'(p_term) + 16'(i_term) + 16'(d_term);
    if (pid_sum > 16'sd2047)       pid_sat = 12'sd2047;
    else if (pid_sum < -16'sd2048) pid_sat = -12'sd2048;
    else                           pid_sat = pid_sum[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= '0;
      dsat_q    <= '0;
      integ_q   <= '0;
      prev1_q   <= '0;
      prev2_q   <= '0;
      s1_vld_q  <= 1'b0;
      PID_cntrl <= '0;
      cntrl_vld <= 1'b0;
    end else if (!pwr_up) begin
      integ_q   <= '0;
      prev1_q   <= '0;
      prev2_q   <= '0;
      s1_vld_q  <= 1'b0;
      PID_cntrl <= '0;
      cntrl_vld <= 1'b0;
    end else begin
      s1_vld_q <= vld;
      if (vld) begin
        err_q   <= err_d;
        dsat_q  <= dsat_d;
        prev2_q <= prev1_q;
        prev1_q <= err_d;
        if (!integ_ovf) integ_q <= integ_sum;
      end
      // rider_off wins over a same-cycle accumulate
      if (rider_off) integ_q <= '0;
      cntrl_vld <= s1_vld_q;
      if (s1_vld_q) PID_cntrl <= pid_sat;
    end
  end

endmodule

// File: doc/balance_pid.md
# balance_pid

Balance controller stage that consumes the inertial interface's `vld`/`ptch` outputs and produces a saturated PID correction for the motor-drive path. Each valid pitch sample is clamped to a pitch error. The block then updates an overflow-protected integrator and a two-sample derivative history. It emits a registered 12-bit control word with a one-cycle strobe, two clocks after the sample.

## Interface
- `P_COEFF`, default 9: signed 5-bit proportional gain.
- `D_COEFF`, default 11: signed 6-bit derivative gain.
- `clk` input, 1 bit: system clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `vld` input, 1 bit: one-cycle strobe; `ptch` is valid this cycle.
- `ptch` input, 16 bits, signed: pitch sample from the inertial interface.
- `pwr_up` input, 1 bit: controller enable.
- `rider_off` input, 1 bit: when high, clears the integrator.
- `PID_cntrl` output, 12 bits, signed: saturated control word.
- `cntrl_vld` output, 1 bit: one-cycle strobe; `PID_cntrl` was updated.

## Operation
- **Error clamp.** `err = sat10(ptch)`, clamped to [-512, 511].
- **Proportional term.** `P = err * P_COEFF`, 15 bits signed.
- **Integrator.** 18-bit signed `integ`.
  - On an accepted `vld`: `integ <= integ + sext18(err)`.
  - Overflow: if both operands have the same sign and the sum's sign differs, `integ` holds its old value (no wrap).
  - `I = integ[17:6]`, sign-extended to 15 bits.
- **Derivative term.** Two-entry error history `prev1`, `prev2`, both reset to 0.
  - On an accepted `vld`: `diff = err - prev2` (11 bits signed), then `prev2 <= prev1`, `prev1 <= err`.
  - `dsat = sat7(diff)`, clamped to [-64, 63].
  - `D = dsat * D_COEFF`, 13 bits signed, sign-extended to 15.
- **Output.** `sum = P + I + D`, computed at 16 bits; `PID_cntrl = sat12(sum)`, clamped to [-2048, 2047].
- **Pipeline.**
  - Stage 1, at the edge closing the `vld` cycle: register `err_q`, `dsat_q`, and update `integ` and the history; set `s1_vld`.
  - Stage 2, at the next edge: register `PID_cntrl` from `err_q`, `integ`, `dsat_q`; `cntrl_vld <= s1_vld`.
- **`rider_off`.** `integ <= 0` every cycle it is high. This has priority over the `vld` accumulate in the same cycle. P, D, the history and the output pipeline are unaffected.
- **`pwr_up = 0`.**
  - `vld` is ignored.
  - `integ`, `prev1`, `prev2`, `s1_vld` are cleared.
  - `PID_cntrl <= 0`, `cntrl_vld <= 0`.
  - A sample already in stage 1 when `pwr_up` falls is discarded.
- **Back-to-back `vld`** on consecutive cycles: both samples are accepted and processed in order, one output strobe each.

## Timing
- Reset values: `PID_cntrl = 0`, `cntrl_vld = 0`, `integ = 0`, `prev1 = prev2 = 0`, `err_q = dsat_q = 0`, `s1_vld = 0`.
- Reset asserted mid-pipeline: all state clears immediately (asynchronous); a pending strobe is dropped.
- Latency: `vld` high in cycle N gives `PID_cntrl` updated and `cntrl_vld` high in cycle N+2, for exactly one cycle.
- Throughput: one sample per clock.
- `PID_cntrl` holds its value between strobes.
- Ordering: the integrator value used for a sample's output includes that sample's contribution.

## Test plan
- **Reset.** Assert `rst` mid-stream with a `vld` in flight -> `PID_cntrl = 0`, `cntrl_vld` never pulses for that sample, `integ = 0`.
- **Single sample.** Default params, `pwr_up = 1`, one `vld` with `ptch = 16'h0010` from reset -> in cycle N+2, `PID_cntrl = 320` (P 144 + I 0 + D 176), `cntrl_vld` high for one cycle.
- **Output saturation.**
  - First sample `ptch = 16'h7FFF` -> `err = 511`, `PID_cntrl = 2047`.
  - After reset, `ptch = 16'h8000` -> `PID_cntrl = -2048`.
  - Check `dsat = 63` and `dsat = -64` respectively.
- **Integrator overflow.** 257 `vld` pulses of `ptch = 511` -> `integ = 130816` after the 256th, held at 130816 on the 257th and beyond, `I = 2044`; no sign wrap.
- **`rider_off` priority.** Accumulate `integ` to a nonzero value, then assert `rider_off` in the same cycle as a `vld` -> `integ = 0` after that edge, and the output reflects `I = 0`.
- **Power-down and history.**
  - Drop `pwr_up` one cycle after a `vld` -> no `cntrl_vld`, `PID_cntrl = 0`.
  - Re-enable and apply samples 100, 100, 100 -> D diffs 100(sat 63), 100(sat 63), 0.
